// File: rtl/mpsoc_wb_master_bridge.sv
// ---------------------------------------------------------------------------
// mpsoc_wb_master_bridge
//   Wishbone B3 initiator. Converts a command / write-data stream into
//   classic single or incrementing-burst Wishbone cycles with CTI tagging,
//   write-data wait states, slave-error and stall-timeout abort.
//
// Ports
//   wb_clk_i, wb_rst_i          clock, synchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (we, adr, len, sel)
//   wdat_valid/wdat/wdat_ready  write-data stream, ready == write ACK
//   rdat_valid/rdat             read beats, one cycle, no backpressure
//   rsp_valid/rsp_err           one-cycle completion pulse and status
//   wb_*                        Wishbone B3 master signals
// ---------------------------------------------------------------------------
module mpsoc_wb_master_bridge #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int LENW    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [LENW-1:0]   cmd_len,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic              wdat_valid,
  input  logic [DW-1:0]     wdat,
  output logic              wdat_ready,
  output logic              rdat_valid,
  output logic [DW-1:0]     rdat,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [AW-1:0]     wb_adr_o,
  output logic [DW-1:0]     wb_dat_o,
  output logic [DW/8-1:0]   wb_sel_o,
  output logic              wb_we_o,
  output logic [1:0]        wb_bte_o,
  output logic [2:0]        wb_cti_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  input  logic              wb_ack_i,
  input  logic              wb_err_i,
  input  logic [DW-1:0]     wb_dat_i
);

  localparam int TOW = $clog2(TIMEOUT + 1);
  localparam logic [TOW-1:0] TO_LAST = TOW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_WWAIT, S_RESP} state_t;

  state_t            state_q;
  logic              we_q;
  logic [AW-1:0]     adr_q;
  logic [DW/8-1:0]   sel_q;
  logic [LENW-1:0]   cnt_q;
  logic              single_q;
  logic              cyc_q;
  logic              stb_q;
  logic [TOW-1:0]    to_q;
  logic              cmd_ready_q;
  logic              rdat_valid_q;
  logic [DW-1:0]     rdat_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  logic              beat_ack;

  // A write beat whose data has not arrived yet must not be strobed: the
  // strobe is qualified by wdat_valid, and the FSM parks in WWAIT next edge.
  assign wb_stb_o   = stb_q & (~we_q | wdat_valid);
  assign beat_ack   = wb_stb_o & wb_ack_i & ~wb_err_i;
  assign wdat_ready = beat_ack & we_q;
  assign wb_dat_o   = (stb_q & we_q) ? wdat : {DW{1'b0}};

  // Single-beat cycles are classic (000); bursts mark the last beat with 111.
  assign wb_cti_o   = (!cyc_q || single_q) ? 3'b000 :
                      (cnt_q == {LENW{1'b0}}) ? 3'b111 : 3'b010;
  assign wb_bte_o   = 2'b00;
  assign wb_cyc_o   = cyc_q;
  assign wb_adr_o   = adr_q;
  assign wb_sel_o   = sel_q;
  assign wb_we_o    = we_q;
  assign cmd_ready  = cmd_ready_q;
  assign rdat_valid = rdat_valid_q;
  assign rdat       = rdat_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;

  // Bus-cycle FSM with all control outputs registered.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      adr_q        <= {AW{1'b0}};
      sel_q        <= {(DW/8){1'b0}};
      cnt_q        <= {LENW{1'b0}};
      single_q     <= 1'b1;
      cyc_q        <= 1'b0;
      stb_q        <= 1'b0;
      to_q         <= {TOW{1'b0}};
      cmd_ready_q  <= 1'b1;
      rdat_valid_q <= 1'b0;
      rdat_q       <= {DW{1'b0}};
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      rdat_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q        <= cmd_we;
            adr_q       <= cmd_adr;
            sel_q       <= cmd_sel;
            cnt_q       <= cmd_len;
            single_q    <= (cmd_len == {LENW{1'b0}});
            cmd_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            to_q        <= {TOW{1'b0}};
            if (!cmd_we || wdat_valid) begin
              stb_q   <= 1'b1;
              state_q <= S_BUS;
            end else begin
              stb_q   <= 1'b0;
              state_q <= S_WWAIT;
            end
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        S_BUS: begin
          if (we_q && !wdat_valid) begin
            // strobe already masked this cycle; ACK/ERR cannot count here
            stb_q   <= 1'b0;
            state_q <= S_WWAIT;
          end else if (wb_err_i || (!wb_ack_i && (to_q == TO_LAST))) begin
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state_q     <= S_RESP;
          end else if (wb_ack_i) begin
            adr_q <= adr_q + AW'(1);
            cnt_q <= cnt_q - LENW'(1);
            to_q  <= {TOW{1'b0}};
            if (!we_q) begin
              rdat_valid_q <= 1'b1;
              rdat_q       <= wb_dat_i;
            end
            if (cnt_q == {LENW{1'b0}}) begin
              cyc_q       <= 1'b0;
              stb_q       <= 1'b0;
              rsp_valid_q <= 1'b1;
              state_q     <= S_RESP;
            end
          end else begin
            to_q <= to_q + TOW'(1);
          end
        end
        S_WWAIT: begin
          if (wdat_valid) begin
            stb_q   <= 1'b1;
            to_q    <= {TOW{1'b0}};
            state_q <= S_BUS;
          end else begin
            stb_q <= 1'b0;
          end
        end
        S_RESP: begin
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          cyc_q       <= 1'b0;
          stb_q       <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mpsoc_wb_master_bridge.md
Name: mpsoc_wb_master_bridge

Overview:
Wishbone B3 initiator (master) that turns a simple command/data-stream interface into classic single and incrementing-burst Wishbone cycles. It targets word-addressed Wishbone memory slaves such as the mpram block, and is used by DMA and test-infrastructure logic. It handles the CTI/BTE burst tagging, per-beat address increment, write-data wait states, slave errors and a stall timeout.

Parameters:
DW, 32, data width in bits (multiple of 8; SEL width = DW/8)
AW, 8, word-address width
LENW, 4, width of the burst-length field; max burst = 2^LENW beats
TIMEOUT, 255, max cycles STB may stay asserted without ACK/ERR before abort (>=1)

Ports:
wb_clk_i  in  1  clock
wb_rst_i  in  1  reset, synchronous, active-low
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
cmd_we  in  1  1=write burst, 0=read burst
cmd_adr  in  AW  start word address
cmd_len  in  LENW  beats minus 1 (0 = single beat)
cmd_sel  in  DW/8  byte enables applied to every beat
wdat_valid  in  1  write-data beat available
wdat  in  DW  write-data beat
wdat_ready  out  1  beat consumed (equals write ACK)
rdat_valid  out  1  read beat valid (one cycle, no backpressure)
rdat  out  DW  read beat data
rsp_valid  out  1  one-cycle completion pulse
rsp_err  out  1  completion status, valid with rsp_valid
wb_adr_o  out  AW  Wishbone address
wb_dat_o  out  DW  write data
wb_sel_o  out  DW/8  byte select
wb_we_o  out  1  write enable
wb_bte_o  out  2  burst type, always 2'b00 (linear)
wb_cti_o  out  3  cycle type
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_ack_i  in  1  slave acknowledge
wb_err_i  in  1  slave error
wb_dat_i  in  DW  read data

Behaviour:
- Reset (wb_rst_i=0 at a clock edge): state IDLE. cmd_ready=1; wb_cyc_o, wb_stb_o, wb_we_o, rdat_valid, rsp_valid, rsp_err = 0; wb_adr_o, wb_dat_o, rdat = 0; wb_sel_o = 0; wb_cti_o = 3'b000; wb_bte_o = 2'b00. Reset during a burst drops CYC/STB on the next edge and emits no rsp.
- States: IDLE, BUS, WWAIT, RESP.
- IDLE: cmd_ready=1. On accept, latch we/adr/len/sel and set beat counter = cmd_len. Read -> BUS. Write -> BUS if wdat_valid is high at that edge, else WWAIT. CYC/STB are asserted in the cycle after accept.
- BUS: CYC=STB=1. wb_dat_o = wdat (combinational pass-through for writes). CTI = 3'b000 if cmd_len==0; otherwise 3'b010 for non-final beats and 3'b111 for the final beat.
- Beat completes on ACK while STB=1. On completion: adr+1 (wraps modulo 2^AW); counter-1. Read beat: rdat_valid=1 and rdat=wb_dat_i, both registered, so visible one cycle after the ACK. Write beat: wdat_ready=wb_ack_i (combinational).
- After the final ACK: CYC/STB drop next cycle -> RESP.
- Write with wdat_valid=0 at the next-beat boundary: STB drops, CYC stays high -> WWAIT. When wdat_valid=1, STB reasserts next cycle -> BUS. Address and CTI are unchanged across the wait.
- ERR while STB=1: beat is not counted, no rdat_valid and no wdat_ready, CYC/STB drop next cycle, remaining beats are discarded -> RESP with rsp_err=1.
- ACK and ERR together: ERR wins.
- Timeout: a counter clears on every beat start and increments each cycle STB=1 without ACK/ERR. Reaching TIMEOUT aborts exactly as for ERR.
- RESP: rsp_valid=1 for one cycle (rsp_err per outcome), then IDLE. cmd_ready=0 everywhere except IDLE, so at most one command is in flight.
- ACK/ERR arriving while STB=0 are ignored.

Test Plan:
- Single read: cmd adr=0x10, len=0 -> one cycle with CYC/STB=1, CTI=000, WE=0; slave ACK with 0xDEADBEEF -> rdat_valid with rdat=0xDEADBEEF, then rsp_valid=1, rsp_err=0.
- Write burst: adr=0xFE, len=3, sel=4'hF, data 1..4 always valid, slave ACKs every cycle -> addresses FE,FF,00,01 (wraparound); CTI 010,010,010,111; 4 wdat_ready pulses; rsp_err=0.
- Write stall: len=1, wdat_valid low for 3 cycles before beat 2 -> STB low for those cycles, CYC held high; beat 2 at adr+1 with CTI=111.
- Slave error: read len=3, ERR on beat 2 -> exactly 1 rdat_valid, CYC drops next cycle, rsp_err=1.
- Timeout: TIMEOUT=4, slave never responds -> abort after 4 STB cycles, rsp_err=1; the next command is accepted normally.
- Reset mid-burst: wb_rst_i=0 during beat 2 of 4 -> next edge CYC=STB=0, cmd_ready=1, no rsp_valid.
